// File: rtl/iir_pkg.sv
// Purpose : shared sample format and folding constants for the folded IIR datapath.
// Latency : n/a (types and constants only).
// Backpres: n/a.
// Contents: Q10.10 sample width, fraction width, folding factor, sample_t.
package iir_pkg;

    localparam int SAMPLE_W    = 20;   // Q10.10 two's complement
    localparam int FRAC_W      = 10;
    localparam int FOLD_FACTOR = 3;    // clocks per output sample of the folded filter

    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/iir_output_collector_if.sv
// Purpose : groups the collector's control, capture and drain signals into one bundle.
// Latency : n/a (wiring only).
// Backpres: rd_valid/rd_ready handshake on the drain side; capture side has none.
// Ports   : master = environment (drives en, y_in, rd_ready, clr_ovf);
//           slave  = collector (drives rd_valid, rd_data, level, overflow, drop_cnt, sample_cnt).
interface iir_output_collector_if
    import iir_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic              en;
    logic [DATA_W-1:0] y_in;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              clr_ovf;
    logic [7:0]        drop_cnt;
    logic [CNT_W-1:0]  sample_cnt;

    modport master (
        output en, y_in, rd_ready, clr_ovf,
        input  rd_valid, rd_data, level, overflow, drop_cnt, sample_cnt
    );

    modport slave (
        input  en, y_in, rd_ready, clr_ovf,
        output rd_valid, rd_data, level, overflow, drop_cnt, sample_cnt
    );

endinterface

// File: rtl/iir_sync_fifo.sv
// Purpose : first-word-fall-through synchronous FIFO for filter output samples.
// Latency : a push into an empty FIFO is visible on o_dat/o_valid one clock later.
// Backpres: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
// Ports   : clk/rst, i_push/i_push_dat, i_pop, o_dat (head, 0 when empty), o_valid (registered
//           non-empty), o_full, o_empty, o_level.
module iir_sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_push_dat,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_dat,
    output logic                       o_valid,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [LVL_W-1:0]  w_level_nxt;
    logic              r_valid;
    logic              w_pop;
    logic              w_push;

    assign w_pop  = i_pop && (r_level != '0);
    // When full, the slot being vacated by a same-cycle pop is the one written.
    assign w_push = i_push && ((r_level != LVL_W'(DEPTH)) || w_pop);

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LVL_W'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LVL_W'(1);
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); r_level separates full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_nxt;
            r_valid <= (w_level_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign o_dat   = r_valid ? r_mem[r_rd_ptr] : '0;
    assign o_valid = r_valid;
    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule

// File: rtl/iir_output_collector.sv
// Purpose : tracks the fold phase of the folded IIR filter, captures y on the valid phase and
//           buffers samples in a FWFT FIFO; counts captured and dropped samples.
// Latency : a sample captured into an empty FIFO appears on rd_data/rd_valid one clock later.
// Backpres: rd_valid/rd_ready drain; a capture arriving while full with no pop is dropped and
//           flagged (sticky overflow, saturating drop_cnt).
// Ports   : clk, rst (async active-high), bus (slave side of iir_output_collector_if).
module iir_output_collector
    import iir_pkg::*;
#(
    parameter int DATA_W    = SAMPLE_W,
    parameter int FOLD      = FOLD_FACTOR,
    parameter int CAP_PHASE = 2,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    iir_output_collector_if.slave  bus
);

    localparam int                PH_W   = (FOLD > 1) ? $clog2(FOLD) : 1;
    localparam int                LVL_W  = $clog2(DEPTH + 1);
    localparam logic [PH_W-1:0]   CAP_P  = PH_W'(CAP_PHASE);
    localparam logic [PH_W-1:0]   LAST_P = PH_W'(FOLD - 1);

    logic [PH_W-1:0]   r_phase;
    logic              r_overflow;
    logic [7:0]        r_drop_cnt;
    logic [CNT_W-1:0]  r_sample_cnt;

    logic              w_push_req;
    logic              w_push_ok;
    logic              w_drop;
    logic              w_pop;
    logic              w_fifo_valid;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_fifo_dat;
    logic [LVL_W-1:0]  w_fifo_level;

    assign w_push_req = bus.en && (r_phase == CAP_P);
    assign w_pop      = bus.rd_ready && !w_fifo_empty;
    assign w_push_ok  = w_push_req && (!w_fifo_full || w_pop);
    assign w_drop     = w_push_req && w_fifo_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase      <= '0;
            r_overflow   <= 1'b0;
            r_drop_cnt   <= '0;
            r_sample_cnt <= '0;
        end else begin
            // en low parks the phase at 0 so a restart always begins a fresh fold.
            if (!bus.en || (r_phase == LAST_P)) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + PH_W'(1);
            end

            if (w_push_ok) begin
                r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            end

            // A clear wins over a drop in the same cycle; that drop is not recorded.
            if (bus.clr_ovf) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    iir_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push_ok),
        .i_push_dat (bus.y_in),
        .i_pop      (w_pop),
        .o_dat      (w_fifo_dat),
        .o_valid    (w_fifo_valid),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_level    (w_fifo_level)
    );

    assign bus.rd_valid   = w_fifo_valid;
    assign bus.rd_data    = w_fifo_dat;
    assign bus.level      = w_fifo_level;
    assign bus.overflow   = r_overflow;
    assign bus.drop_cnt   = r_drop_cnt;
    assign bus.sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_iir_output_collector.sv
// Purpose : self-checking bench for iir_output_collector: vector table, directed corner
//           sequences and a randomized run against a queue-based reference model.
// Latency : n/a.
// Backpres: rd_ready driven by the bench (constant, toggling and random patterns).
module tb_iir_output_collector;

    localparam int DATA_W    = 20;
    localparam int FOLD      = 3;
    localparam int CAP_PHASE = 2;
    localparam int DEPTH     = 8;
    localparam int CNT_W     = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    iir_output_collector_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    iir_output_collector #(
        .DATA_W    (DATA_W),
        .FOLD      (FOLD),
        .CAP_PHASE (CAP_PHASE),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of stored samples plus the run length of en.
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_pops[$];
    logic [DATA_W-1:0] d_pops[$];
    int                m_en_edges;
    bit                m_ovf;
    int                m_drop;
    int                m_cnt;

    typedef struct {
        logic              en;
        logic [DATA_W-1:0] y;
        logic              rdy;
        logic              clr;
        logic              e_vld;
        logic [DATA_W-1:0] e_dat;
        int                e_lvl;
        int                e_cnt;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pops.delete();
        d_pops.delete();
        m_en_edges = 0;
        m_ovf      = 1'b0;
        m_drop     = 0;
        m_cnt      = 0;
    endtask

    // Advances the model by one clock using the inputs currently driven.
    task automatic model_update();
        bit pop;
        bit preq;
        pop  = (m_q.size() != 0) && bus.rd_ready;
        preq = bus.en && ((m_en_edges % FOLD) == CAP_PHASE);
        if (pop) m_pops.push_back(m_q.pop_front());
        if (preq) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(bus.y_in);
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end else if (!bus.clr_ovf) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        if (bus.clr_ovf) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        m_en_edges = bus.en ? m_en_edges + 1 : 0;
    endtask

    task automatic tick();
        if (bus.rd_valid === 1'b1 && bus.rd_ready) d_pops.push_back(bus.rd_data);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [DATA_W-1:0] e_dat;
        e_dat = (m_q.size() != 0) ? m_q[0] : '0;
        chk({tag, "_vld"},  32'(bus.rd_valid),   32'(m_q.size() != 0));
        chk({tag, "_dat"},  32'(bus.rd_data),    32'(e_dat));
        chk({tag, "_lvl"},  32'(bus.level),      32'(m_q.size()));
        chk({tag, "_ovf"},  32'(bus.overflow),   32'(m_ovf));
        chk({tag, "_drop"}, 32'(bus.drop_cnt),   32'(m_drop));
        chk({tag, "_cnt"},  32'(bus.sample_cnt), 32'(m_cnt));
    endtask

    task automatic compare_pops(input string tag);
        chk({tag, "_npops"}, 32'(d_pops.size()), 32'(m_pops.size()));
        for (int i = 0; i < d_pops.size() && i < m_pops.size(); i++) begin
            chk({tag, "_pop"}, 32'(d_pops[i]), 32'(m_pops[i]));
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.y_in    = '0;
        bus.rd_ready = 1'b0;
        bus.clr_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int first;
        logic [DATA_W-1:0] exp_ovf_seq[9];

        tbl[0] = '{1'b1, 20'h00200, 1'b0, 1'b0, 1'b0, 20'h00000, 0, 0};
        tbl[1] = '{1'b1, 20'h00201, 1'b0, 1'b0, 1'b0, 20'h00000, 0, 0};
        tbl[2] = '{1'b1, 20'h00202, 1'b0, 1'b0, 1'b1, 20'h00202, 1, 1};
        tbl[3] = '{1'b1, 20'h00203, 1'b1, 1'b0, 1'b0, 20'h00000, 0, 1};
        tbl[4] = '{1'b1, 20'h00204, 1'b0, 1'b0, 1'b0, 20'h00000, 0, 1};
        tbl[5] = '{1'b1, 20'h00205, 1'b0, 1'b0, 1'b1, 20'h00205, 1, 2};
        tbl[6] = '{1'b0, 20'h00206, 1'b0, 1'b0, 1'b1, 20'h00205, 1, 2};
        tbl[7] = '{1'b1, 20'h00207, 1'b1, 1'b0, 1'b0, 20'h00000, 0, 2};
        tbl[8] = '{1'b1, 20'h00208, 1'b0, 1'b0, 1'b0, 20'h00000, 0, 2};
        tbl[9] = '{1'b1, 20'h00209, 1'b0, 1'b0, 1'b1, 20'h00209, 1, 3};

        exp_ovf_seq = '{20'd103, 20'd106, 20'd109, 20'd112, 20'd115,
                        20'd118, 20'd121, 20'd124, 20'd136};

        // Reset state.
        rst = 1'b1;
        bus.en = 1'b0; bus.y_in = '0; bus.rd_ready = 1'b0; bus.clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld",  32'(bus.rd_valid),   32'd0);
        chk("rst_dat",  32'(bus.rd_data),    32'd0);
        chk("rst_lvl",  32'(bus.level),      32'd0);
        chk("rst_ovf",  32'(bus.overflow),   32'd0);
        chk("rst_drop", 32'(bus.drop_cnt),   32'd0);
        chk("rst_cnt",  32'(bus.sample_cnt), 32'd0);
        rst = 1'b0;
        model_reset();

        // Vector table.
        for (int i = 0; i < 10; i++) begin
            bus.en = tbl[i].en; bus.y_in = tbl[i].y;
            bus.rd_ready = tbl[i].rdy; bus.clr_ovf = tbl[i].clr;
            tick();
            chk("tbl_vld", 32'(bus.rd_valid),   32'(tbl[i].e_vld));
            chk("tbl_dat", 32'(bus.rd_data),    32'(tbl[i].e_dat));
            chk("tbl_lvl", 32'(bus.level),      32'(tbl[i].e_lvl));
            chk("tbl_cnt", 32'(bus.sample_cnt), 32'(tbl[i].e_cnt));
        end

        // Basic capture: one valid pulse every FOLD clocks.
        do_reset();
        bus.en = 1'b1; bus.y_in = 20'h00200; bus.rd_ready = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("basic_vld", 32'(bus.rd_valid), 32'((k % 3) == 0));
            if ((k % 3) == 0) begin
                chk("basic_dat", 32'(bus.rd_data),    32'h00200);
                chk("basic_cnt", 32'(bus.sample_cnt), 32'(k / 3));
            end
            check_model("basic");
        end

        // Phase tracking with a ramp.
        do_reset();
        bus.en = 1'b1; bus.rd_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.y_in = DATA_W'(k);
            tick();
        end
        chk("ramp_npops", 32'(d_pops.size()), 32'd5);
        for (int i = 0; i < 5 && i < d_pops.size(); i++) begin
            chk("ramp_val", 32'(d_pops[i]), 32'(2 + 3 * i));
        end

        // Overflow, clear priority, full with simultaneous push/pop, drain order.
        do_reset();
        bus.en = 1'b1; bus.rd_ready = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            bus.y_in = DATA_W'(100 + k);
            tick();
        end
        chk("ovf_lvl",  32'(bus.level),    32'd8);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        chk("ovf_drop", 32'(bus.drop_cnt), 32'd2);
        chk("ovf_head", 32'(bus.rd_data),  32'd103);
        for (int k = 31; k <= 32; k++) begin
            bus.y_in = DATA_W'(100 + k);
            tick();
        end
        bus.y_in = DATA_W'(133); bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        chk("clr_flag", 32'(bus.overflow), 32'd0);
        chk("clr_drop", 32'(bus.drop_cnt), 32'd0);
        chk("clr_lvl",  32'(bus.level),    32'd8);
        for (int k = 34; k <= 35; k++) begin
            bus.y_in = DATA_W'(100 + k);
            tick();
        end
        bus.y_in = DATA_W'(136); bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        chk("fullpp_lvl",  32'(bus.level),    32'd8);
        chk("fullpp_drop", 32'(bus.drop_cnt), 32'd0);
        chk("fullpp_ovf",  32'(bus.overflow), 32'd0);
        check_model("fullpp");
        bus.en = 1'b0; bus.rd_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("drain_n", 32'(d_pops.size()), 32'd9);
        for (int i = 0; i < 9 && i < d_pops.size(); i++) begin
            chk("drain_seq", 32'(d_pops[i]), 32'(exp_ovf_seq[i]));
        end
        check_model("drain");

        // Back-pressure: rd_ready toggles every clock.
        do_reset();
        bus.en = 1'b1;
        for (int k = 0; k < 60; k++) begin
            bus.y_in = DATA_W'($urandom);
            bus.rd_ready = k[0];
            tick();
            check_model("bp");
        end
        compare_pops("bp");

        // Asynchronous reset mid-stream with five samples stored.
        do_reset();
        bus.en = 1'b1; bus.rd_ready = 1'b0;
        for (int k = 0; k < 15; k++) begin
            bus.y_in = DATA_W'(k + 50);
            tick();
        end
        chk("pre_rst_lvl", 32'(bus.level), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vld", 32'(bus.rd_valid),   32'd0);
        chk("arst_lvl", 32'(bus.level),      32'd0);
        chk("arst_cnt", 32'(bus.sample_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // en gating: low for 4 clocks, then the next capture lands on the 3rd edge.
        bus.en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_model("engate");
        end
        bus.en = 1'b1;
        first = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (first == 0 && bus.rd_valid === 1'b1) first = k;
        end
        chk("en_restart_edges", 32'(first), 32'd3);
        check_model("engate_end");

        // Randomized run against the model.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            bus.en       = ($urandom_range(0, 7) != 0);
            bus.y_in     = DATA_W'($urandom);
            bus.rd_ready = (k % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            bus.clr_ovf  = ($urandom_range(0, 49) == 0);
            tick();
            check_model("rnd");
        end
        compare_pops("rnd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
